// File: rtl/systolic_operand_skew.sv
// Operand feeder for an N x N output-stationary systolic array.
// Accepts one A column and one B row per beat and drives them onto the west
// and north array edges with diagonal skew. It also sequences the accumulator
// clear, the K feed beats, the pipeline flush and the done pulse for each tile.
//
// state | meaning
// IDLE  | waiting for start; skew lines fed with zeros
// CLEAR | one cycle with pe_rst_n low to clear the PE accumulators
// FEED  | accepting operand beats until K have been taken
// FLUSH | F = 2*(N-1)+PE_LAT zero cycles so the last beat reaches every PE
// DONE  | one-cycle tile_done pulse; array results are final
module systolic_operand_skew #(
  parameter int N       = 4,
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16,
  parameter int K       = 8,
  parameter int PE_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [N*WIDTH_A-1:0] s_a,
  input  logic [N*WIDTH_B-1:0] s_b,
  output logic [N*WIDTH_A-1:0] out_west,
  output logic [N*WIDTH_B-1:0] out_north,
  output logic                 pe_rst_n,
  output logic                 busy,
  output logic                 tile_done
);

  localparam int F       = 2 * (N - 1) + PE_LAT;
  localparam int BEAT_W  = $clog2(K + 1);
  localparam int FLUSH_W = $clog2(F + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic                accept;

  // s_ready is a registered copy of "state == FEED", so this is the handshake.
  assign accept = s_valid & s_ready;

  // Tile sequencer; all control outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
      pe_rst_n  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tile_done <= 1'b0;
          s_ready   <= 1'b0;
          if (start) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            pe_rst_n <= 1'b0;
          end else begin
            busy     <= 1'b0;
            pe_rst_n <= 1'b1;
          end
        end
        CLEAR: begin
          state    <= FEED;
          beat_cnt <= '0;
          s_ready  <= 1'b1;
          pe_rst_n <= 1'b1;
        end
        FEED: begin
          if (accept) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (beat_cnt == BEAT_W'(K - 1)) begin
              state     <= FLUSH;
              s_ready   <= 1'b0;
              flush_cnt <= FLUSH_W'(F - 1);
            end
          end
        end
        FLUSH: begin
          // Down-counter: terminal count 0 marks the last flush cycle.
          if (flush_cnt == '0) begin
            state     <= DONE;
            tile_done <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - FLUSH_W'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          tile_done <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          s_ready   <= 1'b0;
          busy      <= 1'b0;
          tile_done <= 1'b0;
          pe_rst_n  <= 1'b1;
        end
      endcase
    end
  end

  // West edge: row i gets 1+i stages so element i lags row 0 by i cycles.
  for (genvar i = 0; i < N; i++) begin : g_west
    logic [WIDTH_A-1:0] pipe [0:i];

    // Shift every cycle; zeros enter whenever no beat is accepted.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) pipe[s] <= '0;
      end else begin
        pipe[0] <= accept ? s_a[i*WIDTH_A +: WIDTH_A] : '0;
        for (int s = 1; s <= i; s++) pipe[s] <= pipe[s-1];
      end
    end

    assign out_west[i*WIDTH_A +: WIDTH_A] = pipe[i];
  end

  // North edge: column j gets 1+j stages, mirroring the west edge.
  for (genvar j = 0; j < N; j++) begin : g_north
    logic [WIDTH_B-1:0] pipe [0:j];

    // Shift every cycle; zeros enter whenever no beat is accepted.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s <= j; s++) pipe[s] <= '0;
      end else begin
        pipe[0] <= accept ? s_b[j*WIDTH_B +: WIDTH_B] : '0;
        for (int s = 1; s <= j; s++) pipe[s] <= pipe[s-1];
      end
    end

    assign out_north[j*WIDTH_B +: WIDTH_B] = pipe[j];
  end

endmodule

// File: tb/tb_systolic_operand_skew.sv
// Directed bench for systolic_operand_skew (N=4, K=4, PE_LAT=2, so F=8).
// Cycle c below means "sampled 1 time unit after clock edge c", with the
// start pulse sampled at edge 0. Expected values come from the timing rules:
// FEED from edge 1, beat accepted at edge t shows on lane i after edge t+i,
// done after edge (last accept + F).
module tb_systolic_operand_skew;
  localparam int N      = 4;
  localparam int W      = 16;
  localparam int K      = 4;
  localparam int PE_LAT = 2;
  localparam int F      = 2 * (N - 1) + PE_LAT;
  localparam int NC     = 24;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           s_valid;
  logic           s_ready;
  logic [N*W-1:0] s_a;
  logic [N*W-1:0] s_b;
  logic [N*W-1:0] out_west;
  logic [N*W-1:0] out_north;
  logic           pe_rst_n;
  logic           busy;
  logic           tile_done;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] cap_w [NC][N];
  logic [W-1:0] cap_n [NC][N];
  logic         cap_done  [NC];
  logic         cap_ready [NC];
  logic         cap_busy  [NC];
  logic         cap_pern  [NC];

  systolic_operand_skew #(
    .N(N), .WIDTH_A(W), .WIDTH_B(W), .K(K), .PE_LAT(PE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid),
    .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .out_west(out_west),
    .out_north(out_north), .pe_rst_n(pe_rst_n), .busy(busy),
    .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_a(input int c, input int i, input int first, input int gap);
    int d;
    d = c - i - first;
    if (d >= 0 && d % gap == 0 && d / gap < K) return W'(32'h0100 * (d / gap + 1) + i);
    return '0;
  endfunction

  function automatic logic [W-1:0] exp_b(input int c, input int j, input int first, input int gap);
    int d;
    d = c - j - first;
    if (d >= 0 && d % gap == 0 && d / gap < K) return W'(32'h1000 * (d / gap + 1) + j);
    return '0;
  endfunction

  // Runs one tile: beats at edges first, first+gap, ...; optional extra start pulses.
  task automatic drive_tile(input int first, input int gap, input int xs0, input int xs1);
    for (int c = 0; c < NC; c++) begin
      int d;
      d = c - first;
      start = (c == 0) || (c == xs0) || (c == xs1);
      if (d >= 0 && d % gap == 0 && d / gap < K) begin
        s_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
          s_a[i*W +: W] = W'(32'h0100 * (d / gap + 1) + i);
          s_b[i*W +: W] = W'(32'h1000 * (d / gap + 1) + i);
        end
      end else begin
        s_valid = 1'b0;
        s_a = {N{16'hdead}};
        s_b = {N{16'hbeef}};
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        cap_w[c][i] = out_west[i*W +: W];
        cap_n[c][i] = out_north[i*W +: W];
      end
      cap_done[c]  = tile_done;
      cap_ready[c] = s_ready;
      cap_busy[c]  = busy;
      cap_pern[c]  = pe_rst_n;
    end
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      start   = 1'($urandom_range(0, 1));
      s_valid = 1'($urandom_range(0, 1));
      s_a     = {$urandom, $urandom};
      s_b     = {$urandom, $urandom};
      @(posedge clk); #1;
      n_total++;
      if ({out_west, out_north, s_ready, busy, tile_done, pe_rst_n} !== '0)
        $display("FAIL reset_outputs cycle %0d: got west=%h north=%h rdy=%b busy=%b done=%b pe_rst_n=%b, want all 0",
                 c, out_west, out_north, s_ready, busy, tile_done, pe_rst_n);
      else n_pass++;
    end
    rst_n = 1'b1; start = 1'b0; s_valid = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0 || pe_rst_n !== 1'b1)
      $display("FAIL reset_release: got busy=%b pe_rst_n=%b, want 0/1", busy, pe_rst_n);
    else n_pass++;
  endtask

  task automatic test_skew;
    int done_c;
    done_c = 2 + (K - 1) + F;
    drive_tile(2, 1, -1, -1);
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < N; i++) begin
        n_total++;
        if (cap_w[c][i] !== exp_a(c, i, 2, 1))
          $display("FAIL skew_west c=%0d i=%0d: got %h want %h", c, i, cap_w[c][i], exp_a(c, i, 2, 1));
        else n_pass++;
        n_total++;
        if (cap_n[c][i] !== exp_b(c, i, 2, 1))
          $display("FAIL skew_north c=%0d j=%0d: got %h want %h", c, i, cap_n[c][i], exp_b(c, i, 2, 1));
        else n_pass++;
      end
      n_total++;
      if (cap_done[c] !== (c == done_c))
        $display("FAIL skew_done c=%0d: got %b want %b", c, cap_done[c], c == done_c);
      else n_pass++;
      n_total++;
      if (cap_ready[c] !== (c >= 1 && c < 2 + K - 1))
        $display("FAIL skew_ready c=%0d: got %b want %b", c, cap_ready[c], c >= 1 && c < 2 + K - 1);
      else n_pass++;
      n_total++;
      if (cap_busy[c] !== (c <= done_c))
        $display("FAIL skew_busy c=%0d: got %b want %b", c, cap_busy[c], c <= done_c);
      else n_pass++;
      n_total++;
      if (cap_pern[c] !== (c != 0))
        $display("FAIL skew_pe_rst_n c=%0d: got %b want %b", c, cap_pern[c], c != 0);
      else n_pass++;
    end
  endtask

  task automatic test_bubbles;
    int done_c;
    done_c = 3 + 2 * (K - 1) + F;
    drive_tile(3, 2, -1, -1);
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < N; i++) begin
        n_total++;
        if (cap_w[c][i] !== exp_a(c, i, 3, 2))
          $display("FAIL bubble_west c=%0d i=%0d: got %h want %h", c, i, cap_w[c][i], exp_a(c, i, 3, 2));
        else n_pass++;
        n_total++;
        if (cap_n[c][i] !== exp_b(c, i, 3, 2))
          $display("FAIL bubble_north c=%0d j=%0d: got %h want %h", c, i, cap_n[c][i], exp_b(c, i, 3, 2));
        else n_pass++;
      end
      n_total++;
      if (cap_done[c] !== (c == done_c))
        $display("FAIL bubble_done c=%0d: got %b want %b", c, cap_done[c], c == done_c);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset;
    start = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        s_a[i*W +: W] = W'(32'h0100 * (k + 1) + i);
        s_b[i*W +: W] = W'(32'h1000 * (k + 1) + i);
      end
      if (k == 2) rst_n = 1'b0;
      @(posedge clk); #1;
    end
    n_total++;
    if ({out_west, out_north, s_ready, busy, tile_done, pe_rst_n} !== '0)
      $display("FAIL midreset_outputs: got west=%h north=%h rdy=%b busy=%b done=%b pe_rst_n=%b, want all 0",
               out_west, out_north, s_ready, busy, tile_done, pe_rst_n);
    else n_pass++;
    rst_n = 1'b1; s_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_total++;
      if (tile_done !== 1'b0 || out_west !== '0 || busy !== 1'b0)
        $display("FAIL midreset_quiet c=%0d: got done=%b west=%h busy=%b, want 0", c, tile_done, out_west, busy);
      else n_pass++;
    end
    drive_tile(2, 1, -1, -1);
    n_total++;
    if (cap_done[2 + K - 1 + F] !== 1'b1)
      $display("FAIL midreset_fresh_done: got %b want 1", cap_done[2 + K - 1 + F]);
    else n_pass++;
    n_total++;
    if (cap_w[5][3] !== 16'h0103)
      $display("FAIL midreset_fresh_west: got %h want 0103", cap_w[5][3]);
    else n_pass++;
    n_total++;
    if (cap_n[8][3] !== 16'h4003)
      $display("FAIL midreset_fresh_north: got %h want 4003", cap_n[8][3]);
    else n_pass++;
  endtask

  task automatic test_ignored_start;
    int n_done;
    int n_clr;
    drive_tile(2, 1, 3, 8);
    n_done = 0;
    n_clr  = 0;
    for (int c = 0; c < NC; c++) begin
      if (cap_done[c] === 1'b1) n_done++;
      if (cap_pern[c] === 1'b0) n_clr++;
    end
    n_total++;
    if (n_done !== 1) $display("FAIL ignstart_done_count: got %0d want 1", n_done);
    else n_pass++;
    n_total++;
    if (n_clr !== 1) $display("FAIL ignstart_clear_count: got %0d want 1", n_clr);
    else n_pass++;
    n_total++;
    if (cap_done[2 + K - 1 + F] !== 1'b1)
      $display("FAIL ignstart_done_time: got %b want 1", cap_done[2 + K - 1 + F]);
    else n_pass++;
    n_total++;
    if (cap_ready[3] !== 1'b1 || cap_busy[8] !== 1'b1)
      $display("FAIL ignstart_state: got ready3=%b busy8=%b want 1/1", cap_ready[3], cap_busy[8]);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0;
    test_reset;
    test_skew;
    test_bubbles;
    test_mid_reset;
    test_ignored_start;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/systolic_operand_skew.md
# systolic_operand_skew

Operand feeder for the N×N output-stationary systolic array built from `pe` tiles. Each beat accepts one column of A and one row of B, and drives them onto the array's west and north edges with the diagonal skew the array needs. It also clears the PE accumulators before each tile, flushes the pipeline after K beats, and signals when the array results are final and stable.

## Interface
- `N`, 4: array dimension (rows = columns); N ≥ 2
- `WIDTH_A`, 16: A element width (two's complement fixed point; format is opaque here)
- `WIDTH_B`, 16: B element width
- `K`, 8: inner dimension, i.e. beats per tile; K ≥ 1
- `PE_LAT`, 2: cycles from a PE input edge to its updated `result`
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  begin tile; sampled only in IDLE
- `s_valid`  in  1  operand beat valid
- `s_ready`  out  1  operand beat accepted when `s_valid & s_ready`
- `s_a`  in  N*WIDTH_A  A column k; element i at bits [i*WIDTH_A +: WIDTH_A]
- `s_b`  in  N*WIDTH_B  B row k; element j at bits [j*WIDTH_B +: WIDTH_B]
- `out_west`  out  N*WIDTH_A  to `in_west` of PE(i,0)
- `out_north`  out  N*WIDTH_B  to `in_north` of PE(0,j)
- `pe_rst_n`  out  1  array clear, active-low; ANDed with `rst_n` at the array
- `busy`  out  1  high in every state except IDLE
- `tile_done`  out  1  one-cycle pulse; array results are final

## Operation
- FSM states: IDLE, CLEAR, FEED, FLUSH, DONE.
- IDLE: `s_ready` = 0. A sampled `start` moves to CLEAR.
- CLEAR: lasts one cycle; `pe_rst_n` = 0. Then go to FEED with the beat counter at 0.
- FEED: `s_ready` = 1.
  - Each accepted beat increments the beat counter.
  - When `s_valid` is low, a zero beat (A = 0, B = 0) enters the skew lines. Its product is 0, so bubbles are harmless.
  - When the K-th beat is accepted, `s_ready` drops in the next cycle and the FSM enters FLUSH.
- FLUSH: `s_ready` = 0 and zeros enter the skew lines. Lasts F = 2*(N-1) + PE_LAT cycles, counted by a flush counter. Then go to DONE.
- DONE: `tile_done` = 1 for one cycle, then go to IDLE.
- After DONE, the PE results hold their values because the feeder drives only zeros. They are cleared at the next CLEAR.
- Skew lines:
  - A element i passes through 1+i register stages.
  - B element j passes through 1+j register stages.
  - Lines shift every cycle in all states.
  - Lines load zeros in IDLE, CLEAR, FLUSH, DONE, and on FEED cycles without a handshake.
- `start` is ignored outside IDLE.
- Data is passed through unmodified: no arithmetic, no width change, no sign handling.

## Timing
- Reset values (synchronous reset, `rst_n` = 0 at a clock edge):
  - state IDLE, both counters 0
  - all skew registers 0, so `out_west` = `out_north` = 0
  - `s_ready` = 0, `busy` = 0, `tile_done` = 0
  - `pe_rst_n` = 0 during reset, 1 in the first cycle after it
- `start` sampled at edge e0:
  - cycle after e0: state CLEAR, `pe_rst_n` = 0, `busy` = 1
  - following cycle: state FEED, `s_ready` = 1
- A beat accepted at edge t: A element i appears on `out_west[i]` in the cycle after edge t+i; B element j appears on `out_north[j]` in the cycle after edge t+j.
- Back-to-back: `s_valid` held high gives K accepts on K consecutive edges.
- Last beat accepted at edge tK: FLUSH occupies the F cycles that follow. `tile_done` is high in the cycle after FLUSH ends.
  - Minimum start-to-done: 1 + K + F + 1 cycles.
- `s_valid` asserted while `s_ready` = 0: nothing is accepted. Data does not need to be held stable outside a handshake.
- Reset mid-tile:
  - everything returns to reset values in the next cycle
  - the partial tile is discarded
  - no `tile_done` pulse is emitted
  - `pe_rst_n` low during reset clears the array
- The beat counter is wide enough for K. The flush counter is wide enough for F. Neither wraps.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with random inputs → all outputs 0 and `pe_rst_n` = 0. First cycle after reset: `busy` = 0, `pe_rst_n` = 1.
- Skew: N=4, K=4, `s_valid` high, beat k has A[i] = 16'h0100*(k+1)+i and B[j] = 16'h1000*(k+1)+j.
  - `out_west[i]` shows the sequence 1..4 starting i cycles after `out_west[0]`; same offsets for `out_north[j]`.
  - Zeros before and after each sequence.
- Bubbles: same data with `s_valid` low on every other cycle → exactly 4 accepts; zeros interleaved identically on both edges; `tile_done` 4 cycles later than the back-to-back case.
- End-to-end with a 4×4 `pe` array: A = I, B = 1.0 in all entries (16'h0100) → after `tile_done`, every PE result equals B. A second tile with A = 2·I yields 16'h0200 everywhere, confirming CLEAR worked.
- Reset mid-tile: assert `rst_n` = 0 after 2 of 4 beats → no `tile_done`, outputs zero. A fresh tile then completes correctly.
- Ignored start: pulse `start` during FEED and during FLUSH → no state change, exactly one `tile_done`, `pe_rst_n` low only once.
